// File: rtl/ddram_ioctl_upload_if.sv
// Upload-side ioctl handshake plus DDRAM read port, bundled for ddram_ioctl_upload.
// slave = the upload block; master = the hps_io / DDRAM environment driving it.
interface ddram_ioctl_upload_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        cache_inval;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic [3:0]  ddram_burstcnt;
    logic        ddram_busy;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, cache_inval,
               ddram_busy, ddram_dout, ddram_dout_ready,
        output ioctl_din, ioctl_wait, ddram_rd, ddram_addr, ddram_burstcnt
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, cache_inval,
               ddram_busy, ddram_dout, ddram_dout_ready,
        input  ioctl_din, ioctl_wait, ddram_rd, ddram_addr, ddram_burstcnt
    );
endinterface

// File: rtl/ddram_ioctl_upload.sv
// Serves 16-bit ioctl upload reads from 64-bit DDRAM words through a one-line cache.
// Hit/out-of-range: data next cycle; miss: 1 + busy cycles + DDRAM latency + 1, ddram_busy holds the request.
module ddram_ioctl_upload #(
    parameter logic [28:0] BASE_ADDR    = 29'h0,
    parameter logic [26:0] UPLOAD_BYTES = 27'h10000
) (
    input  logic                    i_clk_sys,
    input  logic                    i_reset,
    ddram_ioctl_upload_if.slave     i_bus
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_line;
    logic        r_valid;
    logic [23:0] r_tag;
    logic [1:0]  r_lane;
    logic [15:0] r_din;
    logic        r_wait;
    logic        r_ddram_rd;
    logic [28:0] r_ddram_addr;
    logic        r_upload_d;
    // Tracks a request the DDRAM still owes us; it must survive reset so a
    // late response is never mistaken for the answer to a new request.
    logic        r_rd_outstanding = 1'b0;

    logic [23:0] w_tag;
    logic [1:0]  w_lane;
    logic        w_inval;
    logic        w_req;
    logic        w_oob;
    logic        w_hit;
    logic        w_accept;
    logic        w_outstanding_nxt;

    function automatic logic [15:0] lane_sel(input logic [63:0] line, input logic [1:0] lane);
        return line[{lane, 4'b0000} +: 16];
    endfunction

    assign w_tag             = i_bus.ioctl_addr[26:3];
    assign w_lane            = i_bus.ioctl_addr[2:1];
    assign w_inval           = i_bus.cache_inval | (r_upload_d & ~i_bus.ioctl_upload);
    assign w_req             = i_bus.ioctl_rd & i_bus.ioctl_upload;
    assign w_oob             = (i_bus.ioctl_addr >= UPLOAD_BYTES);
    assign w_hit             = r_valid & (r_tag == w_tag) & ~i_bus.cache_inval;
    assign w_accept          = r_ddram_rd & ~i_bus.ddram_busy;
    assign w_outstanding_nxt = w_accept | (r_rd_outstanding & ~i_bus.ddram_dout_ready);

    always_ff @(posedge i_clk_sys) begin
        r_rd_outstanding <= w_outstanding_nxt;
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= w_outstanding_nxt ? S_DRAIN : S_IDLE;
            r_din        <= 16'h0000;
            r_wait       <= 1'b0;
            r_ddram_rd   <= 1'b0;
            r_ddram_addr <= 29'h0;
            r_valid      <= 1'b0;
            r_upload_d   <= 1'b0;
        end else begin
            r_upload_d <= i_bus.ioctl_upload;
            if (w_inval) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rd_outstanding) begin
                        r_state <= S_DRAIN;
                    end else if (w_req) begin
                        if (w_oob) begin
                            r_din <= 16'hFFFF;
                        end else if (w_hit) begin
                            r_din <= lane_sel(r_line, w_lane);
                        end else begin
                            r_wait       <= 1'b1;
                            r_tag        <= w_tag;
                            r_lane       <= w_lane;
                            r_ddram_addr <= BASE_ADDR + {5'd0, w_tag};
                            r_ddram_rd   <= 1'b1;
                            r_state      <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (!i_bus.ddram_busy) begin
                        r_ddram_rd <= 1'b0;
                        r_state    <= S_WAIT_DATA;
                    end
                end

                S_WAIT_DATA: begin
                    // A coincident invalidate still answers the HPS but leaves the line unusable.
                    if (i_bus.ddram_dout_ready) begin
                        r_line  <= i_bus.ddram_dout;
                        r_valid <= ~w_inval;
                        r_din   <= lane_sel(i_bus.ddram_dout, r_lane);
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (!w_outstanding_nxt) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_bus.ioctl_din      = r_din;
    assign i_bus.ioctl_wait     = r_wait;
    assign i_bus.ddram_rd       = r_ddram_rd;
    assign i_bus.ddram_addr     = r_ddram_addr;
    assign i_bus.ddram_burstcnt = 4'h1;
endmodule

// File: tb/tb_ddram_ioctl_upload.sv
// Directed vector bench for ddram_ioctl_upload with an inline single-request DDRAM responder.
module tb_ddram_ioctl_upload;
    localparam logic [28:0] BASE = 29'h100;
    localparam logic [63:0] D0 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D1 = 64'h8888_7777_6666_5555;
    localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D3 = 64'h4444_3333_9999_1111;
    localparam logic [63:0] D4 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D5 = 64'h0004_0003_0002_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddram_ioctl_upload_if bus();

    ddram_ioctl_upload #(.BASE_ADDR(BASE), .UPLOAD_BYTES(27'h10000)) dut (
        .i_clk_sys (clk),
        .i_reset   (rst),
        .i_bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // pre: 0 none, 1 cache_inval pulse before, 2 ioctl_upload low/high before, 3 cache_inval with ioctl_rd
    typedef struct {
        logic [26:0] addr;
        logic [1:0]  pre;
        bit          xrd;
        bit          xinv;
        int          busy_n;
        logic [63:0] data;
        logic [15:0] exp_din;
        bit          exp_miss;
        logic [28:0] exp_da;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input vec_t v, input int idx);
        int    nrd = 0, nacc = 0, nwait = 0, resp_cnt = 0, busy_left;
        bit    done = 0, addr_ok = 1;
        string nm;
        busy_left = v.busy_n;
        nm = $sformatf("v%0d", idx);
        if (v.pre == 2'd1) begin
            bus.cache_inval = 1'b1; tick(); bus.cache_inval = 1'b0;
        end else if (v.pre == 2'd2) begin
            bus.ioctl_upload = 1'b0; tick(); bus.ioctl_upload = 1'b1; tick();
        end
        bus.ioctl_addr  = v.addr;
        bus.ioctl_rd    = 1'b1;
        bus.cache_inval = (v.pre == 2'd3);
        tick();
        bus.ioctl_rd    = 1'b0;
        bus.cache_inval = 1'b0;
        for (int c = 0; c < 60; c++) begin
            bus.ddram_dout_ready = 1'b0;
            bus.cache_inval      = 1'b0;
            if (v.xrd) begin
                bus.ioctl_rd   = (c == 0);
                bus.ioctl_addr = (c == 0) ? 27'h2E : v.addr;
            end
            if (bus.ioctl_wait) nwait++;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.ddram_dout_ready = 1'b1;
                    bus.ddram_dout       = v.data;
                    bus.cache_inval      = v.xinv;
                end
            end
            bus.ddram_busy = 1'b0;
            if (bus.ddram_rd) begin
                nrd++;
                if (bus.ddram_addr !== v.exp_da) addr_ok = 0;
                if (busy_left > 0) begin
                    bus.ddram_busy = 1'b1;
                    busy_left--;
                end else begin
                    nacc++;
                    resp_cnt = 2;
                end
            end
            if (!bus.ioctl_wait && !bus.ddram_rd && resp_cnt == 0 && !bus.ddram_dout_ready) begin
                done = 1;
                break;
            end
            tick();
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_din"}, bus.ioctl_din, v.exp_din);
        chk({nm, "_nacc"}, nacc, v.exp_miss ? 1 : 0);
        chk({nm, "_rd_cycles"}, nrd, v.exp_miss ? v.busy_n + 1 : 0);
        chk({nm, "_wait_seen"}, (nwait > 0), v.exp_miss);
        if (v.exp_miss) chk({nm, "_addr"}, addr_ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{27'h0,       2'd0, 1'b0, 1'b0, 0, D0,    16'h1111, 1'b1, BASE};
        vecs[1]  = '{27'h2,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h2222, 1'b0, 29'h0};
        vecs[2]  = '{27'h4,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h3333, 1'b0, 29'h0};
        vecs[3]  = '{27'h6,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h4444, 1'b0, 29'h0};
        vecs[4]  = '{27'h8,       2'd0, 1'b0, 1'b0, 5, D1,    16'h5555, 1'b1, 29'h101};
        vecs[5]  = '{27'hE,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h8888, 1'b0, 29'h0};
        vecs[6]  = '{27'h10000,   2'd0, 1'b0, 1'b0, 0, 64'h0, 16'hFFFF, 1'b0, 29'h0};
        vecs[7]  = '{27'hFFFE,    2'd0, 1'b0, 1'b0, 1, D2,    16'hAAAA, 1'b1, 29'h20FF};
        vecs[8]  = '{27'h7FFFFFF, 2'd0, 1'b0, 1'b0, 0, 64'h0, 16'hFFFF, 1'b0, 29'h0};
        vecs[9]  = '{27'h0,       2'd0, 1'b0, 1'b0, 0, D0,    16'h1111, 1'b1, BASE};
        vecs[10] = '{27'h2,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h2222, 1'b0, 29'h0};
        vecs[11] = '{27'h2,       2'd1, 1'b0, 1'b0, 0, D3,    16'h9999, 1'b1, BASE};
        vecs[12] = '{27'h4,       2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h3333, 1'b0, 29'h0};
        vecs[13] = '{27'h6,       2'd2, 1'b0, 1'b0, 0, D3,    16'h4444, 1'b1, BASE};
        vecs[14] = '{27'h6,       2'd3, 1'b0, 1'b0, 0, D3,    16'h4444, 1'b1, BASE};
        vecs[15] = '{27'h20,      2'd0, 1'b1, 1'b0, 2, D4,    16'hF00D, 1'b1, 29'h104};
        vecs[16] = '{27'h30,      2'd0, 1'b0, 1'b1, 0, D5,    16'h0001, 1'b1, 29'h106};
        vecs[17] = '{27'h32,      2'd0, 1'b0, 1'b0, 0, D5,    16'h0002, 1'b1, 29'h106};
        vecs[18] = '{27'h36,      2'd0, 1'b0, 1'b0, 0, 64'h0, 16'h0004, 1'b0, 29'h0};

        rst                  = 1'b1;
        bus.ioctl_upload     = 1'b1;
        bus.ioctl_rd         = 1'b0;
        bus.ioctl_addr       = 27'h0;
        bus.cache_inval      = 1'b0;
        bus.ddram_busy       = 1'b0;
        bus.ddram_dout       = 64'h0;
        bus.ddram_dout_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_din", bus.ioctl_din, 16'h0000);
        chk("reset_wait", bus.ioctl_wait, 1'b0);
        chk("reset_ddram_rd", bus.ddram_rd, 1'b0);
        chk("reset_ddram_addr", bus.ddram_addr, 29'h0);
        chk("burstcnt", bus.ddram_burstcnt, 4'h1);

        for (int i = 0; i < 19; i++) do_read(vecs[i], i);

        // ioctl_rd without an upload session must do nothing and leave ioctl_din alone
        bus.ioctl_upload = 1'b0;
        bus.ioctl_addr   = 27'h36;
        bus.ioctl_rd     = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("noupl_wait", bus.ioctl_wait, 1'b0);
            chk("noupl_ddram_rd", bus.ddram_rd, 1'b0);
            chk("noupl_din", bus.ioctl_din, 16'h0004);
            tick();
        end
        bus.ioctl_upload = 1'b1;
        tick();

        // reset while the DDRAM owes a response: drain it, ignore requests meanwhile
        bus.ioctl_addr = 27'h40;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        chk("rst_req_rd", bus.ddram_rd, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait", bus.ioctl_wait, 1'b0);
        chk("rst_din", bus.ioctl_din, 16'h0000);
        chk("rst_ddram_rd", bus.ddram_rd, 1'b0);
        bus.ioctl_rd = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        chk("drain_ddram_rd", bus.ddram_rd, 1'b0);
        chk("drain_wait", bus.ioctl_wait, 1'b0);
        tick();
        bus.ddram_dout       = 64'h5A5A_5A5A_5A5A_5A5A;
        bus.ddram_dout_ready = 1'b1;
        tick();
        bus.ddram_dout_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("postdrain_ddram_rd", bus.ddram_rd, 1'b0);
            chk("postdrain_wait", bus.ioctl_wait, 1'b0);
            chk("postdrain_din", bus.ioctl_din, 16'h0000);
            tick();
        end
        do_read('{27'h40, 2'd0, 1'b0, 1'b0, 0, 64'h0000_0000_0000_1234, 16'h1234, 1'b1, 29'h108}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddram_ioctl_upload.md
Name: ddram_ioctl_upload

Overview:
- Serves HPS upload requests (NVRAM/save data, core → HPS) by reading 64-bit words from DDRAM and returning 16-bit ioctl words.
- It is the reverse of the download path, which packs 16-bit ioctl writes into DDRAM.
- It sits between hps_io (upload side) and the DDRAM read port, in the CLK_50M domain. DDRAM read arbitration is handled outside the block.
- A one-line (64-bit) cache lets 3 of every 4 sequential reads complete without DDRAM traffic.

Parameters:
- BASE_ADDR, 29'h0, DDRAM 64-bit word address of upload byte offset 0.
- UPLOAD_BYTES, 27'h10000, size of the uploadable region in bytes; reads at or above it return 16'hFFFF.

Ports:
- clk_sys  in  1  system clock (CLK_50M); the only clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active.
- ioctl_rd  in  1  one-cycle read request strobe.
- ioctl_addr  in  27  byte address; bit 0 is ignored.
- ioctl_din  out  16  read data to HPS.
- ioctl_wait  out  1  high while a read is unresolved.
- cache_inval  in  1  invalidate the cached line; pulsed when the core writes the region.
- ddram_rd  out  1  DDRAM read request.
- ddram_addr  out  29  DDRAM 64-bit word address.
- ddram_burstcnt  out  4  constant 4'h1.
- ddram_busy  in  1  DDRAM cannot accept a request.
- ddram_dout  in  64  DDRAM read data.
- ddram_dout_ready  in  1  ddram_dout valid this cycle.

Behaviour:
- Reset values:
  - ioctl_din = 16'h0000, ioctl_wait = 0, ddram_rd = 0, ddram_addr = 0.
  - Cache valid = 0; state = IDLE.
- rd_outstanding flag:
  - Powers up at 0 and is NOT cleared by reset.
  - Set when a DDRAM read is accepted (ddram_rd & !ddram_busy).
  - Cleared when ddram_dout_ready is seen.
  - While it is set outside WAIT_DATA, the block stays in DRAIN.
- Line and lane:
  - Line tag = ioctl_addr[26:3].
  - Lane = ioctl_addr[2:1]; lane 0 = bits [15:0], lane 3 = bits [63:48] (little endian).
- States: IDLE, REQ, WAIT_DATA, DRAIN.
- IDLE, on ioctl_rd & ioctl_upload:
  - Address ≥ UPLOAD_BYTES: next cycle ioctl_din = 16'hFFFF, no wait, no DDRAM access.
  - Cache hit (valid & tag match): next cycle ioctl_din = selected lane, ioctl_wait stays 0.
  - Miss: ioctl_wait = 1 from the next cycle; latch tag and lane; ddram_addr = BASE_ADDR + tag (29-bit, wraps mod 2^29); go to REQ.
- ioctl_rd without ioctl_upload is ignored.
- REQ:
  - ddram_rd = 1; ddram_addr is held stable while ddram_busy.
  - On the first cycle with !ddram_busy, drop ddram_rd next cycle and go to WAIT_DATA.
- WAIT_DATA, on ddram_dout_ready:
  - Store ddram_dout in the line, set valid, drive ioctl_din = latched lane.
  - ioctl_wait = 0 on the following cycle; go to IDLE.
- ioctl_rd while ioctl_wait = 1 is a protocol violation: ignored, no state change.
- Read-miss latency: 1 cycle to enter REQ, plus busy cycles, plus DDRAM latency, plus 1 cycle to output.
- DRAIN: entered from reset when rd_outstanding = 1; returns to IDLE when the flag clears. The response is discarded and the cache is not filled.
- Invalidation sources (cache_inval, or the falling edge of ioctl_upload):
  - Valid is cleared the next cycle.
  - If invalidation coincides with a fill in WAIT_DATA, the data is still returned to ioctl_din but valid stays 0.
- Simultaneous ioctl_rd and cache_inval in IDLE: treated as a miss.
- Reset mid-transaction: returns to IDLE (or DRAIN) and drops ioctl_wait; the in-flight request gets no answer.
- ioctl_din holds its value between reads.

Test Plan:
1. Sequential read of bytes 0,2,4,6 with DDRAM word 0 = 64'h4444_3333_2222_1111:
   - Exactly one ddram_rd at ddram_addr = BASE_ADDR.
   - ioctl_din = 1111, 2222, 3333, 4444.
   - ioctl_wait asserted only for byte 0.
2. Read byte 8 with ddram_busy held 5 cycles:
   - ddram_rd stays high 6 cycles with ddram_addr = BASE_ADDR+1 stable.
   - Response 64'h8888_7777_6666_5555 → ioctl_din = 5555.
3. Read at ioctl_addr = UPLOAD_BYTES → ioctl_din = FFFF, ioctl_wait never asserted, no ddram_rd.
4. Hit on line 0, pulse cache_inval, re-read byte 2 → new DDRAM read issued; the new value is returned.
5. Reset asserted in WAIT_DATA, ddram_dout_ready arrives 3 cycles later, ioctl_rd issued during DRAIN:
   - Response discarded; cache valid = 0.
   - Request ignored; the first request after DRAIN triggers a fresh ddram_rd.
6. ioctl_rd pulsed while ioctl_wait = 1 → ignored; exactly one DDRAM read; first request's data returned.
